// File: rtl/snf_qos_retry_pkg.sv
// Shared definitions for the SNF QoS admission / retry block: REQ flit field
// layout, response field widths, queue entry formats and grant FSM states.
package snf_qos_retry_pkg;

    // REQ flit layout (opaque bits above ALLOWRETRY travel untouched)
    localparam int unsigned REQ_FLIT_W = 32;
    localparam int unsigned QOS_LSB    = 0;
    localparam int unsigned QOS_W      = 4;
    localparam int unsigned NODEID_W   = 11;
    localparam int unsigned SRCID_LSB  = 4;
    localparam int unsigned TXNID_W    = 12;
    localparam int unsigned TXNID_LSB  = 15;
    localparam int unsigned AR_BIT     = 27;
    localparam int unsigned PCRDTYPE_W = 4;

    typedef logic [REQ_FLIT_W-1:0] req_flit_t;

    // Retry queue entry: everything a RetryAck needs
    typedef struct packed {
        logic [NODEID_W-1:0]   srcid;
        logic [TXNID_W-1:0]    txnid;
        logic [PCRDTYPE_W-1:0] pcrdtype;
    } retry_ent_t;

    // Pend-grant queue entry: everything a PCrdGrant needs
    typedef struct packed {
        logic [NODEID_W-1:0]   srcid;
        logic [PCRDTYPE_W-1:0] pcrdtype;
    } grant_ent_t;

    typedef enum logic {
        GNT_IDLE = 1'b0,
        GNT_BUSY = 1'b1
    } gnt_state_e;

endpackage

// File: rtl/snf_qos_fifo.sv
// Small synchronous FIFO with asynchronous reset; head shows the oldest entry.
module snf_qos_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             push_full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic [CW-1:0]    count;
    logic             do_push;
    logic             do_pop;

    assign empty     = (count == '0);
    assign push_full = (count == CW'(DEPTH));
    assign head      = mem[rd_ptr];
    assign do_pop    = pop & ~empty;
    assign do_push   = push & ~push_full;

    // Storage, pointers and occupancy; pointers wrap explicitly for any DEPTH
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= (wr_ptr == AW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= (rd_ptr == AW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
            end
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/snf_qos_retry.sv
// SNF RXREQ admission control: accepts or retries each s0 REQ flit against the
// free tracker count with a QoS reserve, queues RetryAcks and PCrdGrants.
module snf_qos_retry
    import snf_qos_retry_pkg::*;
#(
    parameter int unsigned XP_LCRD_NUM_PARAM = 4,
    parameter int unsigned TRK_NUM_PARAM     = 16,
    parameter int unsigned QOS_HI_THR_PARAM  = 8,
    parameter int unsigned QOS_RSV_NUM_PARAM = 2,
    parameter int unsigned PCRD_FIFO_DEPTH   = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rxreq_valid_s0,
    input  logic [REQ_FLIT_W-1:0] rxreqflit_s0,
    output logic                  rxreq_retry_enable_s0,
    output logic                  qos_req_valid_s1,
    output logic [REQ_FLIT_W-1:0] qos_reqflit_s1,
    input  logic                  trk_entry_free_s1,
    output logic                  retryack_valid_s1,
    output logic [NODEID_W-1:0]   retryack_tgtid_s1,
    output logic [TXNID_W-1:0]    retryack_txnid_s1,
    output logic [PCRDTYPE_W-1:0] retryack_pcrdtype_s1,
    input  logic                  txrsp_retryack_won_s1,
    output logic                  pcrdgrant_valid_s1,
    output logic [NODEID_W-1:0]   pcrdgrant_tgtid_s1,
    output logic [PCRDTYPE_W-1:0] pcrdgrant_pcrdtype_s1,
    input  logic                  txrsp_pcrdgrant_won_s1
);

    localparam int unsigned CNT_W = $clog2(TRK_NUM_PARAM + 1);

    logic [CNT_W-1:0]    free_cnt;
    logic [CNT_W-1:0]    rsv_cnt;
    logic [CNT_W:0]      avail;
    logic [QOS_W-1:0]    s0_qos;
    logic [NODEID_W-1:0] s0_srcid;
    logic [TXNID_W-1:0]  s0_txnid;
    logic                s0_ar;
    logic                lo_ok;
    logic                retry;
    logic                acc_free;
    logic                acc_rsv;
    logic                gnt_start;
    logic                gnt_pop;
    logic                retry_full;
    logic                retry_empty;
    logic                pend_full;
    logic                pend_empty;
    retry_ent_t          retry_push;
    retry_ent_t          retry_head;
    grant_ent_t          pend_push;
    grant_ent_t          pend_head;
    gnt_state_e          gnt_state;
    gnt_state_e          gnt_state_nxt;

    assign s0_qos   = rxreqflit_s0[QOS_LSB +: QOS_W];
    assign s0_srcid = rxreqflit_s0[SRCID_LSB +: NODEID_W];
    assign s0_txnid = rxreqflit_s0[TXNID_LSB +: TXNID_W];
    assign s0_ar    = rxreqflit_s0[AR_BIT];

    assign lo_ok    = (32'(s0_qos) >= QOS_HI_THR_PARAM) || (32'(free_cnt) > QOS_RSV_NUM_PARAM);
    assign retry    = rxreq_valid_s0 & s0_ar & ((free_cnt == '0) | ~lo_ok);
    assign acc_free = rxreq_valid_s0 & s0_ar & ~retry;
    assign acc_rsv  = rxreq_valid_s0 & ~s0_ar;

    // Entries available to a grant once this cycle's accept and release settle
    assign avail = {1'b0, free_cnt} - (CNT_W + 1)'(acc_free) + (CNT_W + 1)'(trk_entry_free_s1);

    assign rxreq_retry_enable_s0 = retry;

    assign retry_push = '{srcid: s0_srcid, txnid: s0_txnid, pcrdtype: '0};
    assign pend_push  = '{srcid: s0_srcid, pcrdtype: '0};

    assign retryack_valid_s1     = ~retry_empty;
    assign retryack_tgtid_s1     = retry_head.srcid;
    assign retryack_txnid_s1     = retry_head.txnid;
    assign retryack_pcrdtype_s1  = retry_head.pcrdtype;
    assign pcrdgrant_valid_s1    = (gnt_state == GNT_BUSY);
    assign pcrdgrant_tgtid_s1    = pend_head.srcid;
    assign pcrdgrant_pcrdtype_s1 = pend_head.pcrdtype;

    snf_qos_fifo #(
        .WIDTH($bits(retry_ent_t)),
        .DEPTH(XP_LCRD_NUM_PARAM)
    ) u_retry_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (retry),
        .push_data(retry_push),
        .pop      (txrsp_retryack_won_s1),
        .push_full(retry_full),
        .empty    (retry_empty),
        .head     (retry_head)
    );

    snf_qos_fifo #(
        .WIDTH($bits(grant_ent_t)),
        .DEPTH(PCRD_FIFO_DEPTH)
    ) u_pend_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (retry),
        .push_data(pend_push),
        .pop      (gnt_pop),
        .push_full(pend_full),
        .empty    (pend_empty),
        .head     (pend_head)
    );

    // Grant handshake state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gnt_state <= GNT_IDLE;
        end else begin
            gnt_state <= gnt_state_nxt;
        end
    end

    // Grant start when a grant is pending and an entry is left after accepts; pop on won
    always_comb begin
        gnt_state_nxt = gnt_state;
        gnt_start     = 1'b0;
        gnt_pop       = 1'b0;
        case (gnt_state)
            GNT_IDLE: begin
                if (!pend_empty && (avail != '0)) begin
                    gnt_start     = 1'b1;
                    gnt_state_nxt = GNT_BUSY;
                end
            end
            GNT_BUSY: begin
                if (txrsp_pcrdgrant_won_s1) begin
                    gnt_pop       = 1'b1;
                    gnt_state_nxt = GNT_IDLE;
                end
            end
            default: gnt_state_nxt = GNT_IDLE;
        endcase
    end

    // Free and reserved entry counters; all contributions may land in one cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            free_cnt <= CNT_W'(TRK_NUM_PARAM);
            rsv_cnt  <= '0;
        end else begin
            free_cnt <= free_cnt - CNT_W'(acc_free) + CNT_W'(trk_entry_free_s1) - CNT_W'(gnt_start);
            rsv_cnt  <= rsv_cnt + CNT_W'(gnt_start) - CNT_W'(acc_rsv);
        end
    end

    // Accepted flit handed to the tracker one cycle later
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            qos_req_valid_s1 <= 1'b0;
            qos_reqflit_s1   <= '0;
        end else begin
            qos_req_valid_s1 <= acc_free | acc_rsv;
            if (acc_free | acc_rsv) begin
                qos_reqflit_s1 <= rxreqflit_s0;
            end
        end
    end

    a_rsv_underflow: assert property (@(posedge clk) disable iff (rst)
        !(rxreq_valid_s0 && !s0_ar && (rsv_cnt == '0)));
    a_cnt_bound: assert property (@(posedge clk) disable iff (rst)
        (32'(free_cnt) + 32'(rsv_cnt)) <= TRK_NUM_PARAM);
    a_retry_overflow: assert property (@(posedge clk) disable iff (rst)
        !(retry && retry_full));
    a_pend_overflow: assert property (@(posedge clk) disable iff (rst)
        !(retry && pend_full));

endmodule

// File: tb/tb_snf_qos_retry.sv
// Self-checking bench for snf_qos_retry: directed scenarios plus randomized
// traffic compared every cycle against a queue-based admission model.
module tb_snf_qos_retry;
    import snf_qos_retry_pkg::*;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic                  rxreq_valid_s0 = 1'b0;
    logic [REQ_FLIT_W-1:0] rxreqflit_s0 = '0;
    logic                  rxreq_retry_enable_s0;
    logic                  qos_req_valid_s1;
    logic [REQ_FLIT_W-1:0] qos_reqflit_s1;
    logic                  trk_entry_free_s1 = 1'b0;
    logic                  retryack_valid_s1;
    logic [NODEID_W-1:0]   retryack_tgtid_s1;
    logic [TXNID_W-1:0]    retryack_txnid_s1;
    logic [PCRDTYPE_W-1:0] retryack_pcrdtype_s1;
    logic                  txrsp_retryack_won_s1 = 1'b0;
    logic                  pcrdgrant_valid_s1;
    logic [NODEID_W-1:0]   pcrdgrant_tgtid_s1;
    logic [PCRDTYPE_W-1:0] pcrdgrant_pcrdtype_s1;
    logic                  txrsp_pcrdgrant_won_s1 = 1'b0;

    always #5 clk = ~clk;

    snf_qos_retry #(
        .XP_LCRD_NUM_PARAM(4),
        .TRK_NUM_PARAM    (16),
        .QOS_HI_THR_PARAM (8),
        .QOS_RSV_NUM_PARAM(2),
        .PCRD_FIFO_DEPTH  (16)
    ) dut (
        .clk                   (clk),
        .rst                   (rst),
        .rxreq_valid_s0        (rxreq_valid_s0),
        .rxreqflit_s0          (rxreqflit_s0),
        .rxreq_retry_enable_s0 (rxreq_retry_enable_s0),
        .qos_req_valid_s1      (qos_req_valid_s1),
        .qos_reqflit_s1        (qos_reqflit_s1),
        .trk_entry_free_s1     (trk_entry_free_s1),
        .retryack_valid_s1     (retryack_valid_s1),
        .retryack_tgtid_s1     (retryack_tgtid_s1),
        .retryack_txnid_s1     (retryack_txnid_s1),
        .retryack_pcrdtype_s1  (retryack_pcrdtype_s1),
        .txrsp_retryack_won_s1 (txrsp_retryack_won_s1),
        .pcrdgrant_valid_s1    (pcrdgrant_valid_s1),
        .pcrdgrant_tgtid_s1    (pcrdgrant_tgtid_s1),
        .pcrdgrant_pcrdtype_s1 (pcrdgrant_pcrdtype_s1),
        .txrsp_pcrdgrant_won_s1(txrsp_pcrdgrant_won_s1)
    );

    int errors = 0;
    int checks = 0;

    // Reference model: tracker accounting and the two response queues
    int        m_free;
    int        m_rsv;
    int        m_occ;
    bit        m_busy;
    int        rq_src[$];
    int        rq_txn[$];
    int        pq_src[$];
    bit        m_s1_v;
    req_flit_t m_s1_flit;

    // Snapshots of DUT outputs from the most recent step, for literal checks
    logic                snap_retry;
    logic                snap_s1_v;
    logic                snap_rack_v;
    logic [NODEID_W-1:0] snap_rack_tgt;
    logic [TXNID_W-1:0]  snap_rack_txn;
    logic                snap_gnt_v;
    logic [NODEID_W-1:0] snap_gnt_tgt;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic req_flit_t mk_flit(input int qos, input int src, input int txn,
                                          input bit ar, input int pad);
        req_flit_t f;
        f = '0;
        f[QOS_LSB +: QOS_W]      = qos[QOS_W-1:0];
        f[SRCID_LSB +: NODEID_W] = src[NODEID_W-1:0];
        f[TXNID_LSB +: TXNID_W]  = txn[TXNID_W-1:0];
        f[AR_BIT]                = ar;
        f[REQ_FLIT_W-1 -: 4]     = pad[3:0];
        return f;
    endfunction

    task automatic model_reset();
        m_free = 16;
        m_rsv  = 0;
        m_occ  = 0;
        m_busy = 1'b0;
        rq_src.delete();
        rq_txn.delete();
        pq_src.delete();
        m_s1_v    = 1'b0;
        m_s1_flit = '0;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_retry_en"}, 64'(rxreq_retry_enable_s0), 64'(0));
        chk({tag, "_s1_valid"}, 64'(qos_req_valid_s1), 64'(0));
        chk({tag, "_s1_flit"}, 64'(qos_reqflit_s1), 64'(0));
        chk({tag, "_rack_valid"}, 64'(retryack_valid_s1), 64'(0));
        chk({tag, "_rack_tgt"}, 64'(retryack_tgtid_s1), 64'(0));
        chk({tag, "_rack_txn"}, 64'(retryack_txnid_s1), 64'(0));
        chk({tag, "_rack_type"}, 64'(retryack_pcrdtype_s1), 64'(0));
        chk({tag, "_gnt_valid"}, 64'(pcrdgrant_valid_s1), 64'(0));
        chk({tag, "_gnt_tgt"}, 64'(pcrdgrant_tgtid_s1), 64'(0));
        chk({tag, "_gnt_type"}, 64'(pcrdgrant_pcrdtype_s1), 64'(0));
    endtask

    // One clock cycle: drive, compare at the negedge, then advance the model
    task automatic step(input bit v, input bit ar, input int qos, input int src, input int txn,
                        input bit rel, input bit wr, input bit wg, input int pad);
        req_flit_t f;
        bit exp_retry, acc_f, acc_r, start;
        f = mk_flit(qos, src, txn, ar, pad);
        rxreq_valid_s0         = v;
        rxreqflit_s0           = f;
        trk_entry_free_s1      = rel;
        txrsp_retryack_won_s1  = wr;
        txrsp_pcrdgrant_won_s1 = wg;
        @(negedge clk);
        exp_retry = v && ar && (m_free == 0 || !(qos >= 8 || m_free > 2));
        chk("retry_en", 64'(rxreq_retry_enable_s0), 64'(exp_retry));
        chk("s1_valid", 64'(qos_req_valid_s1), 64'(m_s1_v));
        if (m_s1_v) chk("s1_flit", 64'(qos_reqflit_s1), 64'(m_s1_flit));
        chk("rack_valid", 64'(retryack_valid_s1), 64'(rq_src.size() > 0));
        if (rq_src.size() > 0) begin
            chk("rack_tgt", 64'(retryack_tgtid_s1), 64'(rq_src[0]));
            chk("rack_txn", 64'(retryack_txnid_s1), 64'(rq_txn[0]));
            chk("rack_type", 64'(retryack_pcrdtype_s1), 64'(0));
        end
        chk("gnt_valid", 64'(pcrdgrant_valid_s1), 64'(m_busy));
        if (m_busy) begin
            chk("gnt_tgt", 64'(pcrdgrant_tgtid_s1), 64'(pq_src[0]));
            chk("gnt_type", 64'(pcrdgrant_pcrdtype_s1), 64'(0));
        end
        chk("free_cnt", 64'(dut.free_cnt), 64'(m_free));
        chk("rsv_cnt", 64'(dut.rsv_cnt), 64'(m_rsv));
        snap_retry    = rxreq_retry_enable_s0;
        snap_s1_v     = qos_req_valid_s1;
        snap_rack_v   = retryack_valid_s1;
        snap_rack_tgt = retryack_tgtid_s1;
        snap_rack_txn = retryack_txnid_s1;
        snap_gnt_v    = pcrdgrant_valid_s1;
        snap_gnt_tgt  = pcrdgrant_tgtid_s1;

        acc_f = v && ar && !exp_retry;
        acc_r = v && !ar;
        start = !m_busy && pq_src.size() > 0 && (m_free - int'(acc_f) + int'(rel)) > 0;
        if (wr && rq_src.size() > 0) begin
            void'(rq_src.pop_front());
            void'(rq_txn.pop_front());
        end
        if (wg && m_busy) begin
            m_busy = 1'b0;
            void'(pq_src.pop_front());
        end
        if (exp_retry) begin
            rq_src.push_back(src & 32'h7ff);
            rq_txn.push_back(txn & 32'hfff);
            pq_src.push_back(src & 32'h7ff);
        end
        if (start) m_busy = 1'b1;
        m_free = m_free - int'(acc_f) + int'(rel) - int'(start);
        m_rsv  = m_rsv + int'(start) - int'(acc_r);
        m_occ  = m_occ + int'(acc_f) + int'(acc_r) - int'(rel);
        m_s1_v = acc_f || acc_r;
        if (m_s1_v) m_s1_flit = f;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk_zero("reset");
        chk("reset_free", 64'(dut.free_cnt), 64'(16));
        rst = 1'b0;

        // 1: sixteen high-QoS flits fill the tracker
        for (int i = 0; i < 16; i++) step(1, 1, 15, i, i, 0, 0, 0, i);
        idle();
        chk("t1_model_free", 64'(m_free), 64'(0));
        chk("t1_s1_last", 64'(snap_s1_v), 64'(1));

        // 2: two entries free, low-QoS flit is held off by the reserve
        step(0, 0, 0, 0, 0, 1, 0, 0, 0);
        step(0, 0, 0, 0, 0, 1, 0, 0, 0);
        step(1, 1, 0, 5, 'h21, 0, 0, 0, 3);
        chk("t2_retry_now", 64'(snap_retry), 64'(1));
        idle();
        chk("t2_rack_valid", 64'(snap_rack_v), 64'(1));
        chk("t2_rack_tgt", 64'(snap_rack_tgt), 64'(5));
        chk("t2_rack_txn", 64'(snap_rack_txn), 64'('h21));
        step(0, 0, 0, 0, 0, 0, 1, 1, 0);
        chk("t2_gnt_tgt", 64'(snap_gnt_tgt), 64'(5));
        idle();
        chk("t2_rack_popped", 64'(snap_rack_v), 64'(0));
        chk("t2_model_cnts", 64'({m_free, m_rsv}), {32'd1, 32'd1});

        // 4: AllowRetry=0 flit uses the granted entry
        step(1, 0, 3, 7, 'h30, 0, 0, 0, 9);
        idle();
        chk("t4_s1_valid", 64'(snap_s1_v), 64'(1));
        chk("t4_model_cnts", 64'({m_free, m_rsv}), {32'd1, 32'd0});
        step(1, 1, 15, 8, 'h31, 0, 0, 0, 0);

        // 3: two retries pending, one release yields one grant to the first
        step(1, 1, 15, 9, 'h40, 0, 0, 0, 0);
        chk("t3_retry_a", 64'(snap_retry), 64'(1));
        step(1, 1, 15, 10, 'h41, 0, 0, 0, 0);
        chk("t3_retry_b", 64'(snap_retry), 64'(1));
        step(0, 0, 0, 0, 0, 1, 0, 0, 0);
        idle();
        chk("t3_gnt_valid", 64'(snap_gnt_v), 64'(1));
        chk("t3_gnt_tgt", 64'(snap_gnt_tgt), 64'(9));
        chk("t3_model_cnts", 64'({m_free, m_rsv}), {32'd0, 32'd1});

        // 5: accept, release and grant start in one cycle
        step(0, 0, 0, 0, 0, 1, 0, 1, 0);
        step(1, 1, 15, 11, 'h50, 1, 0, 0, 0);
        idle();
        chk("t5_model_cnts", 64'({m_free, m_rsv}), {32'd0, 32'd2});
        chk("t5_gnt_tgt", 64'(snap_gnt_tgt), 64'(10));

        // drain responses and reserved entries
        step(0, 0, 0, 0, 0, 0, 1, 0, 0);
        step(0, 0, 0, 0, 0, 0, 1, 1, 0);
        step(1, 0, 1, 12, 'h60, 0, 0, 0, 0);
        step(1, 0, 1, 13, 'h61, 0, 0, 0, 0);

        // 6: four retries back to back, nothing drained
        for (int i = 0; i < 4; i++) step(1, 1, 15, 20 + i, 'h70 + i, 0, 0, 0, 0);
        idle();
        chk("t6_rq_depth", 64'(rq_src.size()), 64'(4));
        chk("t6_rack_tgt", 64'(snap_rack_tgt), 64'(20));

        // reset mid-run drops everything
        rxreq_valid_s0 = 1'b0;
        rxreqflit_s0   = '0;
        trk_entry_free_s1 = 1'b0;
        txrsp_retryack_won_s1  = 1'b0;
        txrsp_pcrdgrant_won_s1 = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        chk_zero("midrst");
        rst = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        idle();

        // randomized traffic
        for (int c = 0; c < 3000; c++) begin
            bit v, ar, rel, wr, wg;
            int qos, src, txn, pad;
            rel = (m_occ > 0) && ($urandom_range(0, 3) == 0);
            v   = ($urandom_range(0, 1) == 1);
            ar  = !((m_rsv > 0) && ($urandom_range(0, 3) == 0));
            if (v && ar && !(rq_src.size() < 4 && pq_src.size() < 16)) v = 1'b0;
            if (!v) ar = 1'b1;
            qos = int'($urandom_range(0, 15));
            src = int'($urandom_range(0, 2047));
            txn = int'($urandom_range(0, 4095));
            pad = int'($urandom_range(0, 15));
            wr  = ($urandom_range(0, 1) == 1);
            wg  = ($urandom_range(0, 1) == 1);
            step(v, ar, qos, src, txn, rel, wr, wg, pad);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
